alu_pipelined_core: RTL and testbench
=====================================

Name: alu_pipelined_core

Overview:
- Next-generation ALU DUT for the alu simulation bench. Generalised in operand width, command-queue depth and multiply latency; adds buffered back-to-back commands, multi-cycle multiply, in-band flush and illegal-op flagging.
- Sits between the ACTIVE alu_in agent interface (command side) and the PASSIVE alu_out agent interface (result side).
- Results complete strictly in command order.

Parameters:
- DATA_WIDTH, 8, operand width in bits (>=2).
- FIFO_DEPTH, 4, command queue entries (power of 2, >=2).
- MUL_LATENCY, 3, cycles from MUL dispatch to done (>=1).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- valid  in  1  command valid.
- ready  out  1  command accepted when valid&&ready at clk edge.
- op  in  3  000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 FLUSH, 110/111 illegal.
- a  in  DATA_WIDTH  operand A.
- b  in  DATA_WIDTH  operand B.
- done  out  1  one-cycle pulse, result valid.
- result  out  2*DATA_WIDTH  result; holds until next done.
- illegal_op  out  1  one-cycle pulse when an illegal op is dequeued.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst==0 at edge): queue emptied, FSM->IDLE, multiply counter cleared. done=0, result=0, illegal_op=0, fifo_count=0, ready=0 during reset; ready=1 from the first cycle after rst deasserts.
- Reset mid-operation aborts the in-flight command with no done.
- ready = !full.
  - No push when full, even if a pop occurs the same cycle.
  - Push and pop in the same cycle when not full leaves fifo_count unchanged.
- FLUSH is not queued. On acceptance in cycle N:
  - queue cleared at edge N; fifo_count=0 at N+1.
  - in-flight command aborted, no done for it or any flushed entry.
  - FSM->IDLE.
  - FLUSH has priority over a simultaneous pop.
- FSM states: IDLE, EXEC, MUL_WAIT.
  - IDLE: if queue non-empty, pop head.
    - ADD/AND/XOR -> EXEC.
    - MUL -> MUL_WAIT with counter = MUL_LATENCY-1.
    - NOP -> stay IDLE, no done.
    - illegal -> illegal_op pulse next cycle, stay IDLE, no done.
  - EXEC: drive done=1 and result for one cycle, then IDLE.
  - MUL_WAIT: decrement each cycle; at 0 drive done=1 with product, then IDLE.
- Latency: ADD/AND/XOR pushed into an empty queue at edge N -> popped at N+1 -> done high in cycle N+2. MUL -> done in cycle N+1+MUL_LATENCY.
- Throughput: one pop per IDLE cycle. Back-to-back single-cycle ops give done every 2 cycles.
- Arithmetic, zero-extended to 2*DATA_WIDTH:
  - ADD: a+b, carry kept in bit DATA_WIDTH.
  - AND: a&b.
  - XOR: a^b.
  - MUL: unsigned full product.
- Operands are captured at push and are not sampled afterwards.
- Queue pointers wrap modulo FIFO_DEPTH.
- No result is dropped or reordered; done never pulses in two consecutive cycles.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with valid=1 -> ready=0, done=0, result=0, fifo_count=0. Release -> ready=1 next cycle.
- Single ops (DATA_WIDTH=8):
  - ADD a=8'hFF b=8'h01 -> done 2 cycles after accept, result=16'h0100.
  - AND 8'hF0&8'h3C -> 16'h0030.
  - XOR 8'hAA^8'h55 -> 16'h00FF.
- Multiply latency: MUL a=8'hFF b=8'hFF, MUL_LATENCY=3 -> done exactly 4 cycles after accept, result=16'hFE01. Also rerun with MUL_LATENCY=1 -> done 2 cycles after accept.
- Full/back-pressure: push 5 ADDs back-to-back with FIFO_DEPTH=4 while a MUL is in flight -> ready=0 when fifo_count=4. Fifth command is accepted only after a pop. Five results arrive in order with correct sums.
- Flush mid-operation: queue 3 ADDs behind an in-flight MUL, then send FLUSH -> no done for any of the 4 commands. fifo_count=0 next cycle. A following ADD 1+2 -> result=16'h0003.
- NOP/illegal and reset abort:
  - op=110 -> illegal_op pulses once, no done.
  - NOP -> no done.
  - rst=0 during MUL_WAIT -> no done, and outputs return to reset values.

Source files
------------

// File: rtl/alu_pipelined_core.sv
// Queued ALU: commands are buffered in a FIFO and executed in order by a small
// IDLE/EXEC/MUL_WAIT sequencer; FLUSH bypasses the queue and aborts in-flight work.
module alu_pipelined_core #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  output logic                          ready,
  input  logic [2:0]                    op,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  output logic                          done,
  output logic [2*DATA_WIDTH-1:0]       result,
  output logic                          illegal_op,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = 2 * DATA_WIDTH;
  localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_AND   = 3'b010,
    OP_XOR   = 3'b011,
    OP_MUL   = 3'b100,
    OP_FLUSH = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_WAIT
  } state_e;

  logic [2:0]            r_op_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_a_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_b_mem  [FIFO_DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_up;
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_res;
  logic          r_done;
  logic [RW-1:0] r_result;
  logic          r_illegal;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_head_op;
  logic [DATA_WIDTH-1:0] w_head_a;
  logic [DATA_WIDTH-1:0] w_head_b;
  logic [RW-1:0]         w_alu;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign ready      = r_up && !w_full;
  assign w_accept   = valid && ready;
  assign w_flush    = w_accept && (op == OP_FLUSH);
  assign w_push     = w_accept && (op != OP_FLUSH);
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !w_flush;

  assign w_head_op  = r_op_mem[r_rptr];
  assign w_head_a   = r_a_mem[r_rptr];
  assign w_head_b   = r_b_mem[r_rptr];

  assign done       = r_done;
  assign result     = r_result;
  assign illegal_op = r_illegal;
  assign fifo_count = r_count;

  // Result is computed at pop time; MUL_WAIT only models the multiplier latency.
  always_comb begin
    w_alu = '0;
    case (w_head_op)
      OP_ADD:  w_alu = RW'(w_head_a) + RW'(w_head_b);
      OP_AND:  w_alu = RW'(w_head_a & w_head_b);
      OP_XOR:  w_alu = RW'(w_head_a ^ w_head_b);
      OP_MUL:  w_alu = RW'(w_head_a) * RW'(w_head_b);
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wptr] <= op;
      r_a_mem[r_wptr]  <= a;
      r_b_mem[r_wptr]  <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_up      <= 1'b0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_res     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_up      <= 1'b1;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (w_flush) begin
        // Flush wins over any pop and suppresses a completion due this edge.
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase

        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_res <= w_alu;
              case (w_head_op)
                OP_ADD, OP_AND, OP_XOR: r_state <= S_EXEC;
                OP_MUL: begin
                  r_state <= S_MUL_WAIT;
                  r_cnt   <= CW'(MUL_LATENCY - 1);
                end
                OP_NOP:  r_state <= S_IDLE;
                default: r_illegal <= 1'b1;
              endcase
            end
          end
          S_EXEC: begin
            r_done   <= 1'b1;
            r_result <= r_res;
            r_state  <= S_IDLE;
          end
          S_MUL_WAIT: begin
            if (r_cnt == '0) begin
              r_done   <= 1'b1;
              r_result <= r_res;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_pipelined_core.sv
// Directed bench for alu_pipelined_core: a queue-based reference model checked
// every cycle, plus literal expectations for latency, results and aborts.
module tb_alu_pipelined_core;

  localparam int unsigned MUL_L = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready,  done,  illegal_op;
  logic [15:0] result;
  logic [2:0]  fifo_count;
  logic        ready1, done1, illegal_op1;
  logic [15:0] result1;
  logic [2:0]  fifo_count1;

  alu_pipelined_core #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MUL_LATENCY(MUL_L)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .op(op), .a(a), .b(b),
    .done(done), .result(result), .illegal_op(illegal_op), .fifo_count(fifo_count)
  );

  alu_pipelined_core #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MUL_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready1), .op(op), .a(a), .b(b),
    .done(done1), .result(result1), .illegal_op(illegal_op1), .fifo_count(fifo_count1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t        m_q[$];
  int          m_remain = 0;
  logic [15:0] m_pend   = '0;
  bit          m_up     = 1'b0;
  bit          e_done   = 1'b0;
  bit          e_ill    = 1'b0;
  logic [15:0] e_res    = '0;
  logic [15:0] res_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: command queue plus a countdown to the in-flight completion.
  initial begin : model
    cmd_t c;
    bit   acc;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_q.delete();
        m_remain = 0;
        m_up     = 1'b0;
        e_done   = 1'b0;
        e_ill    = 1'b0;
        e_res    = '0;
      end else begin
        acc    = valid && m_up && (m_q.size() < 4);
        e_done = 1'b0;
        e_ill  = 1'b0;
        if (acc && op == 3'b101) begin
          m_q.delete();
          m_remain = 0;
        end else begin
          if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
              e_done = 1'b1;
              e_res  = m_pend;
            end
          end else if (m_q.size() > 0) begin
            c = m_q.pop_front();
            case (c.op)
              3'b001: begin m_pend = {8'h00, c.a} + {8'h00, c.b}; m_remain = 1; end
              3'b010: begin m_pend = {8'h00, c.a & c.b};          m_remain = 1; end
              3'b011: begin m_pend = {8'h00, c.a ^ c.b};          m_remain = 1; end
              3'b100: begin m_pend = {8'h00, c.a} * {8'h00, c.b}; m_remain = MUL_L; end
              3'b000: ;
              default: e_ill = 1'b1;
            endcase
          end
          if (acc) m_q.push_back('{op, a, b});
        end
        m_up = 1'b1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ready",      32'(ready),      32'(m_up && (m_q.size() < 4)));
        check("done",       32'(done),       32'(e_done));
        check("result",     32'(result),     32'(e_res));
        check("illegal_op", 32'(illegal_op), 32'(e_ill));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      end
    end
  end

  initial begin : collector
    forever begin
      @(negedge clk);
      if (done) res_log.push_back(result);
    end
  end

  // Called on a negedge; returns on the negedge following acceptance.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int unsigned w = 0;
    valid = 1'b1; op = o; a = x; b = y;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check("send_timeout", 32'(ready), 32'd1);
      valid = 1'b0;
      return;
    end
    @(negedge clk);
    valid = 1'b0;
    op    = 3'b000;
  endtask

  task automatic op_check(input string name, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [15:0] exp_res);
    send(o, x, y);
    @(negedge clk);
    check({name, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    check({name, "_done"},   32'(done),   32'd1);
    check({name, "_result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] bp_exp[6];
    int n_ill;
    int n_done;
    bp_exp = '{16'h000F, 16'h0002, 16'h0005, 16'h0030, 16'h01FE, 16'h0100};

    rst = 1'b0; valid = 1'b1; op = 3'b001; a = 8'h11; b = 8'h22;
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready",  32'(ready),      32'd0);
      check("rst_done",   32'(done),       32'd0);
      check("rst_result", 32'(result),     32'd0);
      check("rst_count",  32'(fifo_count), 32'd0);
    end
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(ready), 32'd1);

    op_check("add", 3'b001, 8'hFF, 8'h01, 16'h0100);
    op_check("and", 3'b010, 8'hF0, 8'h3C, 16'h0030);
    op_check("xor", 3'b011, 8'hAA, 8'h55, 16'h00FF);

    // MUL latency on both instances (MUL_LATENCY 3 and 1).
    send(3'b100, 8'hFF, 8'hFF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) check("mul1_done_early", 32'(done1), 32'd0);
      if (k == 2) begin
        check("mul1_done",   32'(done1),       32'd1);
        check("mul1_result", 32'(result1),     32'hFE01);
        check("mul1_ill",    32'(illegal_op1), 32'd0);
        check("mul1_count",  32'(fifo_count1), 32'd0);
        check("mul1_ready",  32'(ready1),      32'd1);
      end
      if (k < 4) check("mul_done_early", 32'(done), 32'd0);
      else begin
        check("mul_done",   32'(done),   32'd1);
        check("mul_result", 32'(result), 32'hFE01);
      end
    end

    // Back-pressure: five ADDs behind an in-flight MUL.
    @(negedge clk);
    res_log.delete();
    send(3'b100, 8'h03, 8'h05);
    send(3'b001, 8'h01, 8'h01);
    send(3'b001, 8'h02, 8'h03);
    send(3'b001, 8'h10, 8'h20);
    send(3'b001, 8'hFF, 8'hFF);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    check("bp_full_ready", 32'(ready),      32'd0);
    send(3'b001, 8'h80, 8'h80);
    for (int k = 0; k < 60 && res_log.size() < 6; k++) @(negedge clk);
    check("bp_n_results", 32'(res_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_res%0d", i), 32'(res_log[i]), 32'(bp_exp[i]));

    // Flush behind an in-flight MUL with three queued ADDs.
    repeat (2) @(negedge clk);
    res_log.delete();
    send(3'b100, 8'h02, 8'h03);
    send(3'b001, 8'h01, 8'h01);
    send(3'b001, 8'h02, 8'h02);
    send(3'b001, 8'h03, 8'h03);
    send(3'b101, 8'h00, 8'h00);
    check("flush_count", 32'(fifo_count), 32'd0);
    repeat (8) @(negedge clk);
    check("flush_no_done", 32'(res_log.size()), 32'd0);
    op_check("post_flush_add", 3'b001, 8'h01, 8'h02, 16'h0003);

    // Illegal op and NOP: no completion, one illegal pulse.
    @(negedge clk);
    res_log.delete();
    send(3'b110, 8'h12, 8'h34);
    n_ill = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (illegal_op) n_ill++;
    end
    check("illegal_pulses", 32'(n_ill), 32'd1);
    send(3'b000, 8'h12, 8'h34);
    repeat (5) @(negedge clk);
    check("illegal_nop_no_done", 32'(res_log.size()), 32'd0);

    // Reset while a MUL is waiting.
    send(3'b100, 8'h07, 8'h07);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rabort_done",   32'(done),       32'd0);
    check("rabort_result", 32'(result),     32'd0);
    check("rabort_count",  32'(fifo_count), 32'd0);
    check("rabort_ready",  32'(ready),      32'd0);
    check("rabort_ill",    32'(illegal_op), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rabort_no_done", 32'(n_done), 32'd0);
    check("rabort_ready_back", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
